inspection_report_tx: RTL and testbench



---
 rtl/mission_pkg.sv | 43 ++++
 rtl/inspection_report_tx_if.sv | 31 +++
 rtl/inspection_report_tx_uart.sv | 109 ++++++++++
 rtl/inspection_report_tx.sv | 141 ++++++++++++++
 tb/tb_inspection_report_tx.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mission_pkg.sv
// Shared mission types and report framing constants used by the inspection report transmitter.
// Also holds the small framing helpers (parity, report checksum) used by the UART and top levels.
package mission_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        NAVIGATE = 3'd1,
        INSPECT  = 3'd2,
        TRANSMIT = 3'd3,
        COMPLETE = 3'd4
    } state_t;

    typedef logic [1:0] health_t;

    localparam logic [7:0] PKT_HEADER = 8'hA5;
    localparam int         PKT_LEN    = 4;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOAD = 2'd1,
        TX_SEND = 2'd2,
        TX_DONE = 2'd3
    } tx_state_t;

    typedef enum logic [2:0] {
        U_IDLE   = 3'd0,
        U_START  = 3'd1,
        U_DATA   = 3'd2,
        U_PARITY = 3'd3,
        U_STOP   = 3'd4
    } uart_phase_t;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    function automatic logic [7:0] report_check(input logic [7:0] b0,
                                                input logic [7:0] b1,
                                                input logic [7:0] b2);
        return b0 ^ b1 ^ b2;
    endfunction

endpackage

// File: rtl/inspection_report_tx_if.sv
// Task-manager side bundle of the inspection report transmitter: FSM state and health in,
// UART line plus status out.
interface inspection_report_tx_if;
    import mission_pkg::*;

    logic [2:0] state_enc;
    health_t    health_status;
    logic       tx;
    logic       busy;
    logic       transmission_complete;
    logic [7:0] seq_num;

    modport master (
        output state_enc,
        output health_status,
        input  tx,
        input  busy,
        input  transmission_complete,
        input  seq_num
    );

    modport slave (
        input  state_enc,
        input  health_status,
        output tx,
        output busy,
        output transmission_complete,
        output seq_num
    );

endinterface

// File: rtl/inspection_report_tx_uart.sv
// Single-byte UART transmitter (8N1, LSB first; 8E1 when UART_PARITY_EN is defined).
// A start accepted on the last stop-bit cycle chains the next byte with no idle gap.
module uart_tx_byte
    import mission_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    uart_phase_t   phase_r;
    uart_phase_t   phase_nxt_s;
    logic [CW-1:0] baud_r;
    logic [CW-1:0] baud_nxt_s;
    logic [2:0]    bit_r;
    logic [2:0]    bit_nxt_s;
    logic [7:0]    data_r;
    logic [7:0]    data_nxt_s;
    logic          tx_r;
    logic          tx_nxt_s;
    logic          baud_term_s;

    assign baud_term_s = (baud_r == CW'(CLKS_PER_BIT - 1));
    assign done        = (phase_r == U_STOP) && baud_term_s;
    assign busy        = (phase_r != U_IDLE);
    assign tx          = tx_r;

    // Next-state and next-line-level logic; tx is the registered copy of tx_nxt_s.
    always_comb begin
        phase_nxt_s = phase_r;
        baud_nxt_s  = baud_r;
        bit_nxt_s   = bit_r;
        data_nxt_s  = data_r;
        tx_nxt_s    = tx_r;
        if (start) begin
            phase_nxt_s = U_START;
            baud_nxt_s  = CW'(0);
            bit_nxt_s   = 3'd0;
            data_nxt_s  = data;
            tx_nxt_s    = 1'b0;
        end else if (phase_r == U_IDLE) begin
            tx_nxt_s = 1'b1;
        end else if (!baud_term_s) begin
            baud_nxt_s = baud_r + CW'(1);
        end else begin
            baud_nxt_s = CW'(0);
            case (phase_r)
                U_START: begin
                    phase_nxt_s = U_DATA;
                    tx_nxt_s    = data_r[0];
                end
                U_DATA: begin
                    if (bit_r == 3'd7) begin
`ifdef UART_PARITY_EN
                        phase_nxt_s = U_PARITY;
                        tx_nxt_s    = even_parity(data_r);
`else
                        phase_nxt_s = U_STOP;
                        tx_nxt_s    = 1'b1;
`endif
                    end else begin
                        bit_nxt_s = bit_r + 3'd1;
                        tx_nxt_s  = data_r[bit_r + 3'd1];
                    end
                end
`ifdef UART_PARITY_EN
                U_PARITY: begin
                    phase_nxt_s = U_STOP;
                    tx_nxt_s    = 1'b1;
                end
`endif
                U_STOP: begin
                    phase_nxt_s = U_IDLE;
                    tx_nxt_s    = 1'b1;
                end
                default: begin
                    phase_nxt_s = U_IDLE;
                    tx_nxt_s    = 1'b1;
                end
            endcase
        end
    end

    // Bit, baud and line registers; reset forces the line high immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= U_IDLE;
            baud_r  <= CW'(0);
            bit_r   <= 3'd0;
            data_r  <= 8'h00;
            tx_r    <= 1'b1;
        end else begin
            phase_r <= phase_nxt_s;
            baud_r  <= baud_nxt_s;
            bit_r   <= bit_nxt_s;
            data_r  <= data_nxt_s;
            tx_r    <= tx_nxt_s;
        end
    end

endmodule

// File: rtl/inspection_report_tx.sv
// Frames and sends a 4-byte inspection report on each entry to TRANSMIT, then pulses
// transmission_complete. Define UART_PARITY_EN for 8E1 framing (default 8N1).
module inspection_report_tx
    import mission_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] HEADER       = PKT_HEADER
) (
    input  logic                 clk,
    input  logic                 rst,
    inspection_report_tx_if.slave bus
);

    tx_state_t  state_r;
    tx_state_t  state_nxt_s;
    logic       in_tx_s;
    logic       in_tx_prev_r;
    logic       trig_s;
    logic [1:0] idx_r;
    logic [1:0] idx_nxt_s;
    logic [1:0] byte_sel_s;
    logic       start_s;
    logic [7:0] uart_data_s;
    logic       uart_tx_s;
    logic       uart_done_s;
    logic       uart_busy_s;
    logic [7:0] pkt_seq_r;
    health_t    pkt_health_r;
    logic [7:0] seq_r;
    logic       busy_r;
    logic       complete_r;

    assign in_tx_s = (bus.state_enc == TRANSMIT);
    assign trig_s  = in_tx_s && !in_tx_prev_r;

    assign bus.tx                    = uart_tx_s;
    assign bus.busy                  = busy_r;
    assign bus.transmission_complete = complete_r;
    assign bus.seq_num               = seq_r;

    // Report byte selected for the UART by byte index.
    always_comb begin
        case (byte_sel_s)
            2'd0:    uart_data_s = HEADER;
            2'd1:    uart_data_s = pkt_seq_r;
            2'd2:    uart_data_s = {6'b000000, pkt_health_r};
            2'd3:    uart_data_s = report_check(HEADER, pkt_seq_r, {6'b000000, pkt_health_r});
            default: uart_data_s = HEADER;
        endcase
    end

    // Packet FSM: next state, byte index and UART start request.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        byte_sel_s  = idx_r;
        start_s     = 1'b0;
        case (state_r)
            TX_IDLE: begin
                if (trig_s) begin
                    state_nxt_s = TX_LOAD;
                end else begin
                    state_nxt_s = TX_IDLE;
                end
            end
            TX_LOAD: begin
                idx_nxt_s   = 2'd0;
                byte_sel_s  = 2'd0;
                start_s     = 1'b1;
                state_nxt_s = TX_SEND;
            end
            TX_SEND: begin
                if (uart_done_s) begin
                    if (idx_r != 2'(PKT_LEN - 1)) begin
                        idx_nxt_s  = idx_r + 2'd1;
                        byte_sel_s = idx_r + 2'd1;
                        start_s    = 1'b1;
                    end else begin
                        state_nxt_s = TX_DONE;
                    end
                end else if (!uart_busy_s) begin
                    // UART idle while a byte should be in flight: abandon the packet.
                    state_nxt_s = TX_IDLE;
                end else begin
                    state_nxt_s = TX_SEND;
                end
            end
            TX_DONE: begin
                state_nxt_s = TX_IDLE;
            end
            default: begin
                state_nxt_s = TX_IDLE;
            end
        endcase
    end

    // Control registers: state, trigger history, packet capture, sequence and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= TX_IDLE;
            in_tx_prev_r <= 1'b0;
            idx_r        <= 2'd0;
            pkt_seq_r    <= 8'h00;
            pkt_health_r <= 2'b00;
            seq_r        <= 8'h00;
            busy_r       <= 1'b0;
            complete_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            in_tx_prev_r <= in_tx_s;
            idx_r        <= idx_nxt_s;
            if ((state_r == TX_IDLE) && trig_s) begin
                pkt_seq_r    <= seq_r;
                pkt_health_r <= bus.health_status;
            end else begin
                pkt_seq_r    <= pkt_seq_r;
                pkt_health_r <= pkt_health_r;
            end
            if (state_r == TX_DONE) begin
                seq_r <= seq_r + 8'd1;
            end else begin
                seq_r <= seq_r;
            end
            busy_r     <= (state_nxt_s != TX_IDLE);
            complete_r <= (state_nxt_s == TX_DONE);
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .data  (uart_data_s),
        .tx    (uart_tx_s),
        .done  (uart_done_s),
        .busy  (uart_busy_s)
    );

endmodule

// File: tb/tb_inspection_report_tx.sv
// Scoreboard bench for inspection_report_tx: a UART decoder and a completion-pulse monitor
// pop expectations pushed by the directed stimulus.
`timescale 1ns/1ps
module tb_inspection_report_tx;
    import mission_pkg::*;

    localparam int C = 4;
`ifdef UART_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int PKT_CYC = 4 * BITS * C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] exp_byte_q[$];
    int         exp_start_q[$];
    int         exp_pulse_q[$];

    inspection_report_tx_if bus();

    inspection_report_tx #(
        .CLKS_PER_BIT(C),
        .HEADER      (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_pkt(input int t, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3);
        exp_byte_q.push_back(8'hA5); exp_start_q.push_back(t + 2);
        exp_byte_q.push_back(b1);    exp_start_q.push_back(t + 2 + BITS * C);
        exp_byte_q.push_back(b2);    exp_start_q.push_back(t + 2 + 2 * BITS * C);
        exp_byte_q.push_back(b3);    exp_start_q.push_back(t + 2 + 3 * BITS * C);
        exp_pulse_q.push_back(t + 2 + PKT_CYC);
    endtask

    task automatic trigger(input logic [1:0] h, output int t);
        @(posedge clk); #1;
        bus.health_status = h;
        bus.state_enc     = 3'd3;
        t = cyc;
    endtask

    task automatic release_tx();
        @(posedge clk); #1;
        bus.state_enc = 3'd2;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (bus.busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, bus.busy}, 32'd0);
    endtask

    // UART decoder: mid-bit sampling, aborts the byte if reset is seen.
    initial begin : uart_mon
        logic [10:0] bits;
        int          s;
        logic        ok;
        logic [7:0]  eb;
        int          es;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || bus.tx !== 1'b0) continue;
            s    = cyc;
            ok   = 1'b1;
            bits = 11'h7FF;
            for (int i = 0; i < BITS && ok; i++) begin
                for (int k = 0; k < ((i == 0) ? C / 2 : C) && ok; k++) begin
                    @(negedge clk);
                    if (rst !== 1'b0) ok = 1'b0;
                end
                bits[i] = bus.tx;
            end
            if (!ok) continue;
            if (exp_byte_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL uart_unexpected_byte actual=%0h required=none (cycle %0d)", bits[8:1], s);
            end else begin
                eb = exp_byte_q.pop_front();
                es = exp_start_q.pop_front();
                check("uart_byte", {24'd0, bits[8:1]}, {24'd0, eb});
                check("uart_byte_start_cycle", s, es);
                check("uart_start_stop", {30'd0, bits[0], bits[BITS-1]}, 32'd1);
`ifdef UART_PARITY_EN
                check("uart_parity", {31'd0, bits[9]}, {31'd0, ^eb});
`endif
            end
        end
    end

    // Completion pulse monitor: every high cycle must match a queued expectation.
    initial begin : pulse_mon
        forever begin
            @(negedge clk);
            if (bus.transmission_complete === 1'b1) begin
                if (exp_pulse_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL complete_unexpected actual=cycle %0d required=none", cyc);
                end else begin
                    check("complete_pulse_cycle", cyc, exp_pulse_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int         t;
        logic [7:0] b2;
        bus.state_enc     = 3'd0;
        bus.health_status = 2'b00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("reset_state", {21'd0, bus.tx, bus.busy, bus.transmission_complete, bus.seq_num},
                  {21'd0, 1'b1, 1'b0, 1'b0, 8'h00});
        end

        // Packet 1: held in TRANSMIT for 500 cycles, only one packet may go out.
        @(posedge clk); #1 bus.state_enc = 3'd2;
        trigger(2'b10, t);
        push_pkt(t, 8'h00, 8'h02, 8'hA7);
        repeat (500) @(posedge clk);
        #1 bus.state_enc = 3'd2;
        @(negedge clk);
        check("pkt1_seq_after", {24'd0, bus.seq_num}, 32'd1);
        check("pkt1_busy_after", {31'd0, bus.busy}, 32'd0);

        // Packet 2.
        trigger(2'b01, t);
        push_pkt(t, 8'h01, 8'h01, 8'hA5);
        release_tx();
        wait_idle("pkt2_idle");
        check("pkt2_seq_after", {24'd0, bus.seq_num}, 32'd2);

        // Packet 3: health toggled and a retrigger attempt while busy.
        trigger(2'b11, t);
        push_pkt(t, 8'h02, 8'h03, 8'hA4);
        repeat (50) @(posedge clk);
        #1 bus.health_status = 2'b00;
        release_tx();
        @(posedge clk); #1 bus.state_enc = 3'd3;
        release_tx();
        wait_idle("pkt3_idle");
        check("pkt3_seq_after", {24'd0, bus.seq_num}, 32'd3);

        // Packet 4: reset at T+60 aborts mid-packet; only b0 completes.
        trigger(2'b10, t);
        exp_byte_q.push_back(8'hA5);
        exp_start_q.push_back(t + 2);
        repeat (60) @(posedge clk);
        #1 rst = 1'b1;
        bus.state_enc = 3'd2;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_state", {21'd0, bus.tx, bus.busy, bus.transmission_complete, bus.seq_num},
              {21'd0, 1'b1, 1'b0, 1'b0, 8'h00});

        // Fresh packet after the abort.
        @(posedge clk);
        trigger(2'b01, t);
        push_pkt(t, 8'h00, 8'h01, 8'hA4);
        release_tx();
        wait_idle("pkt5_idle");
        check("pkt5_seq_after", {24'd0, bus.seq_num}, 32'd1);

        // Walk the sequence number up to 255.
        for (int s = 1; s <= 254; s++) begin
            b2 = {6'b000000, s[1:0]};
            trigger(s[1:0], t);
            push_pkt(t, s[7:0], b2, 8'hA5 ^ s[7:0] ^ b2);
            release_tx();
            wait_idle("walk_idle");
        end
        check("seq_at_255", {24'd0, bus.seq_num}, 32'd255);

        // Sequence 255 packet, then wrap to 0.
        trigger(2'b10, t);
        push_pkt(t, 8'hFF, 8'h02, 8'h58);
        release_tx();
        wait_idle("wrap_idle");
        check("seq_wrap", {24'd0, bus.seq_num}, 32'd0);

        repeat (20) @(negedge clk);
        check("byte_queue_drained", exp_byte_q.size(), 32'd0);
        check("pulse_queue_drained", exp_pulse_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
